// File: rtl/axi_lite_arbiter.sv
// axi_lite_arbiter: merges a read-only fetch port (m0) and a read/write LSU
// port (m1) onto one AXI-lite manager port. Round-robin per transaction,
// one transaction in flight, 1-cycle arbitration in IDLE, then a purely
// combinational path for the granted channels until the response handshake.
module axi_lite_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    // m0: fetch unit, read only
    input  logic [ADDR_W-1:0] m0_araddr_i,
    input  logic              m0_arvalid_i,
    output logic              m0_arready_o,
    output logic [DATA_W-1:0] m0_rdata_o,
    output logic [1:0]        m0_rresp_o,
    output logic              m0_rvalid_o,
    input  logic              m0_rready_i,
    // m1: load/store unit, read/write
    input  logic [ADDR_W-1:0] m1_araddr_i,
    input  logic              m1_arvalid_i,
    output logic              m1_arready_o,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic [1:0]        m1_rresp_o,
    output logic              m1_rvalid_o,
    input  logic              m1_rready_i,
    input  logic [ADDR_W-1:0] m1_awaddr_i,
    input  logic              m1_awvalid_i,
    output logic              m1_awready_o,
    input  logic [DATA_W-1:0] m1_wdata_i,
    input  logic [STRB_W-1:0] m1_wstrb_i,
    input  logic              m1_wvalid_i,
    output logic              m1_wready_o,
    output logic [1:0]        m1_bresp_o,
    output logic              m1_bvalid_o,
    input  logic              m1_bready_i,
    // downstream subordinate port
    output logic [ADDR_W-1:0] s_araddr_o,
    output logic              s_arvalid_o,
    input  logic              s_arready_i,
    input  logic [DATA_W-1:0] s_rdata_i,
    input  logic [1:0]        s_rresp_i,
    input  logic              s_rvalid_i,
    output logic              s_rready_o,
    output logic [ADDR_W-1:0] s_awaddr_o,
    output logic              s_awvalid_o,
    input  logic              s_awready_i,
    output logic [DATA_W-1:0] s_wdata_o,
    output logic [STRB_W-1:0] s_wstrb_o,
    output logic              s_wvalid_o,
    input  logic              s_wready_i,
    input  logic [1:0]        s_bresp_i,
    input  logic              s_bvalid_i,
    output logic              s_bready_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR      = 3'd3,
        WR_RESP = 3'd4
    } state_e;

    state_e state_q, state_d;
    logic   last_q, last_d;       // index of the most recent grant
    logic   gnt_q, gnt_d;         // 0 = m0, 1 = m1
    logic   aw_done_q, aw_done_d;
    logic   w_done_q, w_done_d;

    logic   m0_req, m1_req, arb_gnt;
    logic   g_arvalid, g_rready;
    logic   aw_hs, w_hs;

    // Request decode and round-robin pick: on a tie the index not equal to last wins
    always_comb begin
        m0_req  = m0_arvalid_i;
        m1_req  = m1_arvalid_i | m1_awvalid_i;
        arb_gnt = (m0_req && m1_req) ? ~last_q : m1_req;
    end

    // Granted-manager selects feeding the handshake decode
    always_comb begin
        g_arvalid = gnt_q ? m1_arvalid_i : m0_arvalid_i;
        g_rready  = gnt_q ? m1_rready_i  : m0_rready_i;
        aw_hs     = m1_awvalid_i & ~aw_done_q & s_awready_i;
        w_hs      = m1_wvalid_i  & ~w_done_q  & s_wready_i;
    end

    // State, grant, round-robin pointer and write-progress flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            gnt_q     <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            gnt_q     <= gnt_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    // Next-state and channel routing; everything idles at zero outside its phase
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        gnt_d     = gnt_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;

        m0_arready_o = 1'b0;
        m0_rdata_o   = '0;
        m0_rresp_o   = 2'b00;
        m0_rvalid_o  = 1'b0;
        m1_arready_o = 1'b0;
        m1_rdata_o   = '0;
        m1_rresp_o   = 2'b00;
        m1_rvalid_o  = 1'b0;
        m1_awready_o = 1'b0;
        m1_wready_o  = 1'b0;
        m1_bresp_o   = 2'b00;
        m1_bvalid_o  = 1'b0;
        s_araddr_o   = '0;
        s_arvalid_o  = 1'b0;
        s_rready_o   = 1'b0;
        s_awaddr_o   = '0;
        s_awvalid_o  = 1'b0;
        s_wdata_o    = '0;
        s_wstrb_o    = '0;
        s_wvalid_o   = 1'b0;
        s_bready_o   = 1'b0;

        case (state_q)
            IDLE: begin
                // Registered decision only: no valid leaks downstream this cycle.
                // An m1 read beats an m1 write raised in the same cycle.
                if (m0_req || m1_req) begin
                    gnt_d  = arb_gnt;
                    last_d = arb_gnt;
                    if (!arb_gnt || m1_arvalid_i) state_d = RD_ADDR;
                    else                          state_d = WR;
                end
            end
            RD_ADDR: begin
                s_arvalid_o = g_arvalid;
                if (gnt_q) begin
                    s_araddr_o   = m1_araddr_i;
                    m1_arready_o = s_arready_i;
                end else begin
                    s_araddr_o   = m0_araddr_i;
                    m0_arready_o = s_arready_i;
                end
                if (g_arvalid && s_arready_i) state_d = RD_DATA;
            end
            RD_DATA: begin
                s_rready_o = g_rready;
                if (gnt_q) begin
                    m1_rvalid_o = s_rvalid_i;
                    m1_rdata_o  = s_rdata_i;
                    m1_rresp_o  = s_rresp_i;
                end else begin
                    m0_rvalid_o = s_rvalid_i;
                    m0_rdata_o  = s_rdata_i;
                    m0_rresp_o  = s_rresp_i;
                end
                if (s_rvalid_i && g_rready) state_d = IDLE;
            end
            WR: begin
                // AW and W run independently; each is masked once accepted
                s_awaddr_o   = m1_awaddr_i;
                s_awvalid_o  = m1_awvalid_i & ~aw_done_q;
                m1_awready_o = s_awready_i & ~aw_done_q;
                s_wdata_o    = m1_wdata_i;
                s_wstrb_o    = m1_wstrb_i;
                s_wvalid_o   = m1_wvalid_i & ~w_done_q;
                m1_wready_o  = s_wready_i & ~w_done_q;
                aw_done_d    = aw_done_q | aw_hs;
                w_done_d     = w_done_q | w_hs;
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = WR_RESP;
                end
            end
            WR_RESP: begin
                m1_bvalid_o = s_bvalid_i;
                m1_bresp_o  = s_bresp_i;
                s_bready_o  = m1_bready_i;
                if (s_bvalid_i && m1_bready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Bench for axi_lite_arbiter: directed manager stimulus, a behavioural
// subordinate, and a scoreboard queue popped by an independent monitor.
module tb_axi_lite_arbiter;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int SW = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic [AW-1:0] m0_araddr_i = '0;
    logic m0_arvalid_i = 1'b0, m0_arready_o;
    logic [DW-1:0] m0_rdata_o;
    logic [1:0] m0_rresp_o;
    logic m0_rvalid_o, m0_rready_i = 1'b1;
    logic [AW-1:0] m1_araddr_i = '0;
    logic m1_arvalid_i = 1'b0, m1_arready_o;
    logic [DW-1:0] m1_rdata_o;
    logic [1:0] m1_rresp_o;
    logic m1_rvalid_o, m1_rready_i = 1'b1;
    logic [AW-1:0] m1_awaddr_i = '0;
    logic m1_awvalid_i = 1'b0, m1_awready_o;
    logic [DW-1:0] m1_wdata_i = '0;
    logic [SW-1:0] m1_wstrb_i = '0;
    logic m1_wvalid_i = 1'b0, m1_wready_o;
    logic [1:0] m1_bresp_o;
    logic m1_bvalid_o, m1_bready_i = 1'b1;
    logic [AW-1:0] s_araddr_o;
    logic s_arvalid_o, s_arready_i;
    logic [DW-1:0] s_rdata_i;
    logic [1:0] s_rresp_i;
    logic s_rvalid_i, s_rready_o;
    logic [AW-1:0] s_awaddr_o;
    logic s_awvalid_o, s_awready_i = 1'b1;
    logic [DW-1:0] s_wdata_o;
    logic [SW-1:0] s_wstrb_o;
    logic s_wvalid_o, s_wready_i = 1'b1;
    logic [1:0] s_bresp_i;
    logic s_bvalid_i, s_bready_o;

    axi_lite_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STRB_W(SW)) dut (
        .clk(clk), .rst(rst),
        .m0_araddr_i(m0_araddr_i), .m0_arvalid_i(m0_arvalid_i), .m0_arready_o(m0_arready_o),
        .m0_rdata_o(m0_rdata_o), .m0_rresp_o(m0_rresp_o), .m0_rvalid_o(m0_rvalid_o), .m0_rready_i(m0_rready_i),
        .m1_araddr_i(m1_araddr_i), .m1_arvalid_i(m1_arvalid_i), .m1_arready_o(m1_arready_o),
        .m1_rdata_o(m1_rdata_o), .m1_rresp_o(m1_rresp_o), .m1_rvalid_o(m1_rvalid_o), .m1_rready_i(m1_rready_i),
        .m1_awaddr_i(m1_awaddr_i), .m1_awvalid_i(m1_awvalid_i), .m1_awready_o(m1_awready_o),
        .m1_wdata_i(m1_wdata_i), .m1_wstrb_i(m1_wstrb_i), .m1_wvalid_i(m1_wvalid_i), .m1_wready_o(m1_wready_o),
        .m1_bresp_o(m1_bresp_o), .m1_bvalid_o(m1_bvalid_o), .m1_bready_i(m1_bready_i),
        .s_araddr_o(s_araddr_o), .s_arvalid_o(s_arvalid_o), .s_arready_i(s_arready_i),
        .s_rdata_i(s_rdata_i), .s_rresp_i(s_rresp_i), .s_rvalid_i(s_rvalid_i), .s_rready_o(s_rready_o),
        .s_awaddr_o(s_awaddr_o), .s_awvalid_o(s_awvalid_o), .s_awready_i(s_awready_i),
        .s_wdata_o(s_wdata_o), .s_wstrb_o(s_wstrb_o), .s_wvalid_o(s_wvalid_o), .s_wready_i(s_wready_i),
        .s_bresp_i(s_bresp_i), .s_bvalid_i(s_bvalid_i), .s_bready_o(s_bready_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural subordinate ----------------
    int            sub_delay = 0;
    logic          sub_fixed = 1'b0;
    logic [DW-1:0] sub_rdata = '0;
    logic [1:0]    sub_rresp = 2'b00;
    logic [1:0]    sub_bresp = 2'b00;
    int            ar_cnt, r_cnt;
    logic          r_pend, got_aw, got_w;
    logic [AW-1:0] r_addr;
    int            aw_hs = 0, w_hs = 0;
    logic [AW-1:0] cap_awaddr;
    logic [DW-1:0] cap_wdata;
    logic [SW-1:0] cap_wstrb;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_arready_i <= 1'b0; s_rvalid_i <= 1'b0; s_rdata_i <= '0; s_rresp_i <= 2'b00;
            s_bvalid_i <= 1'b0; s_bresp_i <= 2'b00;
            r_pend <= 1'b0; ar_cnt <= 0; r_cnt <= 0; r_addr <= '0;
            got_aw <= 1'b0; got_w <= 1'b0;
        end else begin
            if (s_arready_i) begin
                if (s_arvalid_o) begin
                    s_arready_i <= 1'b0; r_addr <= s_araddr_o; r_pend <= 1'b1; r_cnt <= 0;
                end
            end else if (s_arvalid_o) begin
                if (ar_cnt >= sub_delay) begin s_arready_i <= 1'b1; ar_cnt <= 0; end
                else ar_cnt <= ar_cnt + 1;
            end
            if (s_rvalid_i) begin
                if (s_rready_o) s_rvalid_i <= 1'b0;
            end else if (r_pend) begin
                if (r_cnt >= sub_delay) begin
                    s_rvalid_i <= 1'b1;
                    s_rdata_i  <= sub_fixed ? sub_rdata : {32'h5A5A5A5A, r_addr};
                    s_rresp_i  <= sub_rresp;
                    r_pend     <= 1'b0;
                end else r_cnt <= r_cnt + 1;
            end
            if (s_bvalid_i) begin
                if (s_bready_o) s_bvalid_i <= 1'b0;
            end else if (got_aw && got_w) begin
                s_bvalid_i <= 1'b1; s_bresp_i <= sub_bresp; got_aw <= 1'b0; got_w <= 1'b0;
            end
            if (s_awvalid_o && s_awready_i) begin
                got_aw <= 1'b1; aw_hs <= aw_hs + 1; cap_awaddr <= s_awaddr_o;
            end
            if (s_wvalid_o && s_wready_i) begin
                got_w <= 1'b1; w_hs <= w_hs + 1; cap_wdata <= s_wdata_o; cap_wstrb <= s_wstrb_o;
            end
        end
    end

    // ---------------- scoreboard + monitor ----------------
    // who: 0 = m0 R, 1 = m1 R, 2 = m1 B
    typedef struct {
        int         who;
        logic [63:0] data;
        logic [1:0] resp;
    } exp_t;
    exp_t sq[$];

    task automatic push(input int who, input logic [63:0] data, input logic [1:0] resp);
        exp_t e;
        e.who = who; e.data = data; e.resp = resp;
        sq.push_back(e);
    endtask

    task automatic pop_cmp(input int who, input logic [63:0] data, input logic [1:0] resp);
        exp_t e;
        if (sq.size() == 0) begin
            chk("unexpected_resp", 64'(who), 64'hFF);
        end else begin
            e = sq.pop_front();
            chk("resp_owner", 64'(who), 64'(e.who));
            chk("resp_data", data, e.data);
            chk("resp_code", 64'(resp), 64'(e.resp));
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (m0_rvalid_o && m0_rready_i) pop_cmp(0, m0_rdata_o, m0_rresp_o);
            if (m1_rvalid_o && m1_rready_i) pop_cmp(1, m1_rdata_o, m1_rresp_o);
            if (m1_bvalid_o && m1_bready_i) pop_cmp(2, 64'h0, m1_bresp_o);
        end
    end

    // ---------------- helpers ----------------
    function automatic logic sig(input int k);
        case (k)
            0: return m0_arready_o;
            1: return m1_arready_o;
            2: return m1_awready_o;
            3: return m1_wready_o;
            4: return m0_rvalid_o;
            5: return m1_rvalid_o;
            default: return 1'b0;
        endcase
    endfunction

    // Returns at a falling edge where the chosen signal is high
    task automatic wait_hi(input int k, input string nm);
        logic ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sig(k)) begin ok = 1'b1; break; end
        end
        chk({nm, "_timeout"}, 64'(ok), 64'h1);
    endtask

    task automatic drain();
        for (int i = 0; i < 400; i++) begin
            if (sq.size() == 0) break;
            @(negedge clk);
        end
        chk("drain_left", 64'(sq.size()), 64'h0);
        sq.delete();
        @(posedge clk); #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ctl"}, 64'({m0_arready_o, m0_rvalid_o, m1_arready_o, m1_rvalid_o, m1_awready_o,
            m1_wready_o, m1_bvalid_o, s_arvalid_o, s_rready_o, s_awvalid_o, s_wvalid_o, s_bready_o}), 64'h0);
        chk({tag, "_resp"}, 64'({m0_rresp_o, m1_rresp_o, m1_bresp_o, s_wstrb_o}), 64'h0);
        chk({tag, "_addr"}, {s_araddr_o, s_awaddr_o}, 64'h0);
        chk({tag, "_rdata"}, m0_rdata_o | m1_rdata_o, 64'h0);
        chk({tag, "_wdata"}, s_wdata_o, 64'h0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero(tag);
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic m0_issue(input logic [AW-1:0] a, input bit keep);
        m0_araddr_i = a; m0_arvalid_i = 1'b1;
        wait_hi(0, "m0_ar");
        @(posedge clk); #1;
        if (!keep) m0_arvalid_i = 1'b0;
    endtask

    task automatic m1_issue(input logic [AW-1:0] a, input bit keep);
        m1_araddr_i = a; m1_arvalid_i = 1'b1;
        wait_hi(1, "m1_ar");
        @(posedge clk); #1;
        if (!keep) m1_arvalid_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int aw0, w0;
        do_reset("reset");

        // Single m0 read, subordinate waits 2 cycles on AR and R
        sub_delay = 2; sub_fixed = 1'b1; sub_rdata = 64'h1122334455667788;
        push(0, 64'h1122334455667788, 2'b00);
        m0_araddr_i = 32'h8000_0000; m0_arvalid_i = 1'b1;
        #1 chk("idle_no_comb_arvalid", 64'(s_arvalid_o), 64'h0);
        @(posedge clk); #1;
        chk("arb_latency_arvalid", 64'(s_arvalid_o), 64'h1);
        chk("arb_araddr", 64'(s_araddr_o), 64'h8000_0000);
        wait_hi(0, "t1_ar");
        chk("t1_m1_quiet", 64'({m1_arready_o, m1_rvalid_o, m1_awready_o, m1_bvalid_o}), 64'h0);
        @(posedge clk); #1; m0_arvalid_i = 1'b0;
        drain();
        sub_fixed = 1'b0; sub_delay = 0;

        // Continuous contention after reset: m0, m1, m0, m1
        do_reset("reset2");
        push(0, 64'h5A5A5A5A_00001000, 2'b00);
        push(1, 64'h5A5A5A5A_00003000, 2'b00);
        push(0, 64'h5A5A5A5A_00001008, 2'b00);
        push(1, 64'h5A5A5A5A_00003008, 2'b00);
        fork
            begin m0_issue(32'h1000, 1'b1); m0_issue(32'h1008, 1'b0); end
            begin m1_issue(32'h3000, 1'b1); m1_issue(32'h3008, 1'b0); end
        join
        drain();

        // m1 write, W valid 2 cycles ahead of AW, AW held off by the subordinate
        aw0 = aw_hs; w0 = w_hs;
        s_awready_i = 1'b0;
        push(2, 64'h0, 2'b00);
        m1_wdata_i = 64'h0000_0000_DEAD_BEEF; m1_wstrb_i = 8'h0F; m1_wvalid_i = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk("w_only_no_grant", 64'(m1_wready_o), 64'h0);
        m1_awaddr_i = 32'hA000_03F8; m1_awvalid_i = 1'b1;
        wait_hi(3, "t3_w");
        chk("aw_pending_at_w", 64'(s_awvalid_o), 64'h1);
        @(posedge clk); #1;
        chk("w_masked_after_hs", 64'({s_wvalid_o, m1_wready_o}), 64'h0);
        chk("aw_still_valid", 64'(s_awvalid_o), 64'h1);
        m1_wvalid_i = 1'b0;
        @(posedge clk); #1;
        chk("no_b_before_aw", 64'(m1_bvalid_o), 64'h0);
        s_awready_i = 1'b1;
        wait_hi(2, "t3_aw");
        @(posedge clk); #1; m1_awvalid_i = 1'b0;
        drain();
        chk("aw_hs_count", 64'(aw_hs - aw0), 64'h1);
        chk("w_hs_count", 64'(w_hs - w0), 64'h1);
        chk("cap_awaddr", 64'(cap_awaddr), 64'hA000_03F8);
        chk("cap_wdata", cap_wdata, 64'h0000_0000_DEAD_BEEF);
        chk("cap_wstrb", 64'(cap_wstrb), 64'h0F);

        // m1 read and write raised together: read first, IDLE gap, then write
        push(1, 64'h5A5A5A5A_00002000, 2'b00);
        push(2, 64'h0, 2'b00);
        m1_araddr_i = 32'h2000; m1_arvalid_i = 1'b1;
        m1_awaddr_i = 32'h3000; m1_awvalid_i = 1'b1;
        m1_wdata_i = 64'h0123_4567_89AB_CDEF; m1_wstrb_i = 8'hFF; m1_wvalid_i = 1'b1;
        wait_hi(1, "t4_ar");
        chk("t4_no_aw_in_rd_addr", 64'(s_awvalid_o), 64'h0);
        @(posedge clk); #1; m1_arvalid_i = 1'b0;
        wait_hi(5, "t4_r");
        chk("t4_no_aw_in_rd_data", 64'(s_awvalid_o), 64'h0);
        @(posedge clk); #1;
        chk("t4_idle_gap", 64'(s_awvalid_o), 64'h0);
        @(posedge clk); #1;
        chk("t4_aw_after_gap", 64'(s_awvalid_o), 64'h1);
        wait_hi(2, "t4_aw");
        @(posedge clk); #1; m1_awvalid_i = 1'b0; m1_wvalid_i = 1'b0;
        drain();
        chk("t4_cap_awaddr", 64'(cap_awaddr), 64'h3000);
        chk("t4_cap_wdata", cap_wdata, 64'h0123_4567_89AB_CDEF);

        // SLVERR passed through, then back to IDLE
        sub_rresp = 2'b10;
        push(0, 64'h5A5A5A5A_00000040, 2'b10);
        m0_issue(32'h40, 1'b0);
        drain();
        chk("idle_after_err", 64'({s_arvalid_o, s_rready_o, m0_rvalid_o, m0_arready_o}), 64'h0);
        sub_rresp = 2'b00;

        // Reset in RD_DATA with R pending, then a tie must go to m0
        m0_rready_i = 1'b0;
        m0_issue(32'h50, 1'b0);
        wait_hi(4, "t6_r");
        #2 rst = 1'b0;
        #1 check_zero("midrst");
        sq.delete();
        @(posedge clk); #2 rst = 1'b1;
        m0_rready_i = 1'b1;
        @(posedge clk); #1;
        push(0, 64'h5A5A5A5A_00000060, 2'b00);
        push(1, 64'h5A5A5A5A_00000070, 2'b00);
        fork
            m0_issue(32'h60, 1'b0);
            m1_issue(32'h70, 1'b0);
        join
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
